i2s_tx_serializer: RTL and testbench
====================================

Name: i2s_tx_serializer

Overview:
- I2S transmitter: takes stereo sample pairs over a valid/ready stream (the read side of the audio sample FIFO) and serializes them onto BCLK/WS/SD as bus master.
- Generates BCLK and WS from the system clock.
- Sits between the TX sample FIFO and the codec DAC pins.

Parameters:
SAMPLE_W, 24, bits per channel sample; two's complement, sent MSB first.
SLOT_W, 32, BCLK periods per channel slot; must satisfy SLOT_W >= SAMPLE_W+1.
BCLK_DIV, 4, clk cycles per BCLK period; even, >= 2.

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
en  input  1  run enable; sampled only at frame boundaries once running
s_vld  input  1  stereo sample pair valid
s_rdy  output  1  pair accepted this cycle when s_vld & s_rdy
s_data  input  2*SAMPLE_W  {left, right}; left in the upper half
bclk  output  1  bit clock, registered
ws  output  1  word select: 0 = left slot, 1 = right slot; registered
sd  output  1  serial data, registered
underrun  output  1  one-clk pulse when a frame starts with no pair available
underrun_cnt  output  16  saturating underrun count

Behaviour:
- Reset (async, rst_n low): state = IDLE, bclk=0, ws=0, sd=0, s_rdy=0, underrun=0, underrun_cnt=0, div_cnt=0, bit_idx=0, shift regs=0. Applies immediately mid-frame; there is no frame completion.
- States: IDLE and RUN.
  - IDLE: bclk/ws/sd held 0; div_cnt held 0.
  - RUN: div_cnt counts 0..BCLK_DIV-1 and wraps.
  - rise_tick = (div_cnt == BCLK_DIV/2-1): bclk <= 1.
  - fall_tick = (div_cnt == BCLK_DIV-1): bclk <= 0; bit_idx advances 0..2*SLOT_W-1 and wraps.
- frame_tick = (IDLE & en) | (RUN & fall_tick & bit_idx == 2*SLOT_W-1 & en).
- s_rdy = frame_tick. It is combinational from state/counters/en and never depends on s_vld.
- On frame_tick:
  - s_vld=1: latch left/right samples from s_data.
  - s_vld=0: latch zeros; underrun pulses for exactly this cycle; underrun_cnt increments, saturating at 16'hFFFF.
  - Next state RUN, bit_idx=0, div_cnt=0.
  - ws and sd are loaded for bit 0 on the same edge.
- Per bit b, driven on the edge that enters b (every fall_tick, plus the IDLE->RUN edge):
  - p = b mod SLOT_W.
  - ws = 1 for b in SLOT_W-1..2*SLOT_W-2, else 0. WS leads each slot by one BCLK, per standard I2S.
  - sd = 0 at p=0 (the standard I2S one-bit delay).
  - p = 1..SAMPLE_W: sample bit SAMPLE_W-p, MSB first. Left sample when b < SLOT_W, right otherwise.
  - p > SAMPLE_W: sd = 0.
- Receivers sample ws/sd on rising bclk. Data is stable BCLK_DIV/2 clks before the rise.
- Stop: at a frame boundary with en=0, go to IDLE. bclk, ws and sd are 0 from that edge, s_rdy stays 0, and no underrun is flagged. Deasserting en mid-frame has no effect until the boundary.
- Timing:
  - Frame length = 2*SLOT_W*BCLK_DIV clks.
  - Exactly one s_rdy cycle per frame.
  - Back-to-back frames have no gap.
  - Latency from pair acceptance to its left MSB on sd = BCLK_DIV clks (one BCLK, the delay bit).
- The FIFO stays upstream; this block holds only the current pair, so a stalled s_vld never stalls BCLK.

Test Plan:
- Reset, en=1, s_vld=1, s_data={24'hA5A5A5, 24'h5A5A5A}, defaults:
  - s_rdy high for exactly 1 clk.
  - bclk period 4 clks.
  - Capture on rising bclk gives 0, then A5A5A5 MSB first, then 7 zeros; ws=0 for 31 bits, 1 for 32, back to 0.
  - Right slot decodes to 5A5A5A.
- Continuous stream of 4 pairs with a counting pattern:
  - s_rdy every 256 clks.
  - Decoded samples match in order.
  - No bclk gap between frames.
- s_vld low at the second frame boundary:
  - underrun pulses 1 clk; underrun_cnt=1.
  - The second frame decodes as L=0, R=0.
  - The third frame resumes with valid data.
- en dropped at mid-frame, bit 20:
  - The current frame completes all 64 bits.
  - Next boundary enters IDLE with bclk/ws/sd=0, s_rdy never asserts, underrun stays 0.
  - Re-raising en starts a new frame with s_rdy the same cycle.
- rst_n asserted at bit 40 of a frame:
  - All outputs 0 asynchronously, before the next clk edge.
  - After release with en=1, a fresh frame starts at bit 0 with left slot, ws=0.
- Preload underrun_cnt near saturation via forced underruns (bench force to 16'hFFFE), then 3 underruns -> count holds at 16'hFFFF.

Source files
------------

// File: rtl/i2s_tx_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx_serializer_if
// Brief    : Stereo sample-pair stream (valid/ready) feeding the I2S serializer.
// Revision : 1.0
// ============================================================================
interface i2s_tx_serializer_if #(
   parameter int SAMPLE_W = 24
);
   logic                  s_vld;
   logic                  s_rdy;
   logic [2*SAMPLE_W-1:0] s_data;

   modport master (output s_vld, output s_data, input s_rdy);
   modport slave  (input s_vld, input s_data, output s_rdy);
endinterface
`default_nettype wire

// File: rtl/i2s_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx_serializer
// Brief    : I2S bus-master transmitter; generates BCLK/WS and shifts out one
//            stereo pair per frame, zero-filling on underrun.
// Revision : 1.0
// ============================================================================
module i2s_tx_serializer #(
   parameter int SAMPLE_W = 24,
   parameter int SLOT_W   = 32,
   parameter int BCLK_DIV = 4
) (
   input  wire                clk,
   input  wire                rst_n,
   input  wire                en,
   i2s_tx_serializer_if.slave s_if,
   output logic               bclk,
   output logic               ws,
   output logic               sd,
   output logic               underrun,
   output logic [15:0]        underrun_cnt
);
   localparam int DIV_W = $clog2(BCLK_DIV);
   localparam int BIT_W = $clog2(2*SLOT_W);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam logic [DIV_W-1:0] C_RISE  = DIV_W'(BCLK_DIV/2 - 1);
   localparam logic [DIV_W-1:0] C_FALL  = DIV_W'(BCLK_DIV - 1);
   localparam logic [BIT_W-1:0] C_LAST  = BIT_W'(2*SLOT_W - 1);
   localparam logic [BIT_W-1:0] C_SLOT  = BIT_W'(SLOT_W);
   localparam logic [BIT_W-1:0] C_WS_LO = BIT_W'(SLOT_W - 1);
   localparam logic [BIT_W-1:0] C_WS_HI = BIT_W'(2*SLOT_W - 2);
   localparam logic [BIT_W-1:0] C_SMP   = BIT_W'(SAMPLE_W);

   logic [0:0]          state_q, state_d;
   logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
   logic [BIT_W-1:0]    bit_idx_q, bit_idx_d;
   logic                bclk_q, bclk_d;
   logic                ws_q, ws_d;
   logic                sd_q, sd_d;
   logic [SAMPLE_W-1:0] left_q, left_d;
   logic [SAMPLE_W-1:0] right_q, right_d;
   logic [15:0]         underrun_cnt_q, underrun_cnt_d;

   logic                w_rise, w_fall, w_last, w_frame;
   logic [BIT_W-1:0]    w_nb, w_pos, w_idx;
   logic [SAMPLE_W-1:0] w_word, w_shift;
   logic                w_nb_ws, w_nb_sd;

   assign w_rise  = (state_q == S_RUN) && (div_cnt_q == C_RISE);
   assign w_fall  = (state_q == S_RUN) && (div_cnt_q == C_FALL);
   assign w_last  = (bit_idx_q == C_LAST);
   // Gated by rst_n so no pair is offered while the block is held in reset.
   assign w_frame = rst_n && en && ((state_q == S_IDLE) || (w_fall && w_last));

   // Bit that the next fall edge enters, and its slot position / payload bit.
   assign w_nb    = bit_idx_q + BIT_W'(1);
   assign w_pos   = (w_nb >= C_SLOT) ? (w_nb - C_SLOT) : w_nb;
   assign w_word  = (w_nb < C_SLOT) ? left_q : right_q;
   assign w_idx   = C_SMP - w_pos;
   assign w_shift = w_word >> w_idx;
   assign w_nb_sd = (w_pos != '0) && (w_pos <= C_SMP) && w_shift[0];
   assign w_nb_ws = (w_nb >= C_WS_LO) && (w_nb <= C_WS_HI);

   always_comb begin
      state_d        = state_q;
      div_cnt_d      = div_cnt_q;
      bit_idx_d      = bit_idx_q;
      bclk_d         = bclk_q;
      ws_d           = ws_q;
      sd_d           = sd_q;
      left_d         = left_q;
      right_d        = right_q;
      underrun_cnt_d = underrun_cnt_q;

      if (state_q == S_RUN) begin
         div_cnt_d = w_fall ? '0 : div_cnt_q + DIV_W'(1);
         if (w_rise) begin
            bclk_d = 1'b1;
         end
         if (w_fall) begin
            bclk_d = 1'b0;
            if (w_last) begin
               bit_idx_d = '0;
               ws_d      = 1'b0;
               sd_d      = 1'b0;
               if (!en) begin
                  state_d = S_IDLE;
               end
            end else begin
               bit_idx_d = w_nb;
               ws_d      = w_nb_ws;
               sd_d      = w_nb_sd;
            end
         end
      end else begin
         div_cnt_d = '0;
         bit_idx_d = '0;
         bclk_d    = 1'b0;
         ws_d      = 1'b0;
         sd_d      = 1'b0;
      end

      // Bit 0 of a frame is the delay bit with ws low, so only the pair is loaded here.
      if (w_frame) begin
         state_d = S_RUN;
         left_d  = s_if.s_vld ? s_if.s_data[2*SAMPLE_W-1:SAMPLE_W] : '0;
         right_d = s_if.s_vld ? s_if.s_data[SAMPLE_W-1:0] : '0;
         if (!s_if.s_vld && (underrun_cnt_q != 16'hFFFF)) begin
            underrun_cnt_d = underrun_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         div_cnt_q      <= '0;
         bit_idx_q      <= '0;
         bclk_q         <= 1'b0;
         ws_q           <= 1'b0;
         sd_q           <= 1'b0;
         left_q         <= '0;
         right_q        <= '0;
         underrun_cnt_q <= '0;
      end else begin
         state_q        <= state_d;
         div_cnt_q      <= div_cnt_d;
         bit_idx_q      <= bit_idx_d;
         bclk_q         <= bclk_d;
         ws_q           <= ws_d;
         sd_q           <= sd_d;
         left_q         <= left_d;
         right_q        <= right_d;
         underrun_cnt_q <= underrun_cnt_d;
      end
   end

   assign s_if.s_rdy   = w_frame;
   assign underrun     = w_frame && !s_if.s_vld;
   assign bclk         = bclk_q;
   assign ws           = ws_q;
   assign sd           = sd_q;
   assign underrun_cnt = underrun_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_tx_serializer
// Brief    : Scoreboard bench: feeder pushes expected frames, monitor decodes
//            the I2S pins and compares against a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_i2s_tx_serializer;
   localparam int SAMPLE_W = 24;
   localparam int SLOT_W   = 32;
   localparam int BCLK_DIV = 4;
   localparam int FBITS    = 2*SLOT_W;
   localparam int FRAME    = FBITS*BCLK_DIV;
   localparam int PAD      = SLOT_W - SAMPLE_W - 1;

   typedef struct packed {
      logic                  vld;
      logic [2*SAMPLE_W-1:0] data;
   } stim_t;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        bclk, ws, sd, underrun;
   logic [15:0] underrun_cnt;

   i2s_tx_serializer_if #(.SAMPLE_W(SAMPLE_W)) s_bus ();

   i2s_tx_serializer #(
      .SAMPLE_W (SAMPLE_W),
      .SLOT_W   (SLOT_W),
      .BCLK_DIV (BCLK_DIV)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .s_if         (s_bus.slave),
      .bclk         (bclk),
      .ws           (ws),
      .sd           (sd),
      .underrun     (underrun),
      .underrun_cnt (underrun_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int                    checks   = 0;
   int                    failures = 0;
   stim_t                 stim_q[$];
   logic [2*SAMPLE_W-1:0] exp_q[$];
   int                    hs_cnt   = 0;
   logic [15:0]           mdl_cnt  = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_evt(input string name);
      checks++;
      failures++;
      $display("FAIL %s: event missing or unexpected at %0t", name, $time);
   endtask

   function automatic logic [2*SAMPLE_W-1:0] rnd_pair();
      return {16'($urandom), $urandom};
   endfunction

   // Feeder: presents queued pairs; on every handshake the expected frame is pushed.
   initial begin : p_feeder
      logic  hs, hs_vld, loaded;
      stim_t st;
      loaded = 1'b0;
      s_bus.s_vld  = 1'b0;
      s_bus.s_data = '0;
      forever begin
         @(negedge clk);
         hs     = rst_n && s_bus.s_rdy;
         hs_vld = s_bus.s_vld;
         if (hs) exp_q.push_back(s_bus.s_vld ? s_bus.s_data : '0);
         @(posedge clk);
         #2;
         if (hs) begin
            hs_cnt++;
            loaded      = 1'b0;
            s_bus.s_vld = 1'b0;
            if (!hs_vld && mdl_cnt != 16'hFFFF) mdl_cnt = mdl_cnt + 16'd1;
         end
         if (!loaded && stim_q.size() > 0) begin
            st           = stim_q.pop_front();
            s_bus.s_vld  = st.vld;
            s_bus.s_data = st.vld ? st.data : rnd_pair();
            loaded       = 1'b1;
         end
      end
   end

   // Monitor: decodes pins on rising bclk and checks timing and counters.
   logic [FBITS-1:0] cap_ws, cap_sd;
   int               fcnt, cyc, last_rise, last_rdy;
   logic             factive, prev_bclk, rise_ok, rdy_ok;

   task automatic check_frame();
      logic [2*SAMPLE_W-1:0] e;
      logic [SAMPLE_W-1:0]   l, r;
      if (exp_q.size() == 0) begin
         fail_evt("scoreboard_empty");
      end else begin
         e = exp_q.pop_front();
         l = e[2*SAMPLE_W-1:SAMPLE_W];
         r = e[SAMPLE_W-1:0];
         check("frame_sd", cap_sd, {1'b0, l, {PAD{1'b0}}, 1'b0, r, {PAD{1'b0}}});
         check("frame_ws", cap_ws, {{(SLOT_W-1){1'b0}}, {SLOT_W{1'b1}}, 1'b0});
      end
   endtask

   initial begin : p_monitor
      cyc = 0; fcnt = 0; factive = 0; prev_bclk = 0; rise_ok = 0; rdy_ok = 0;
      last_rise = 0; last_rdy = 0; cap_ws = '0; cap_sd = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            factive = 0; fcnt = 0; prev_bclk = 0; rise_ok = 0; rdy_ok = 0;
         end else begin
            if (bclk && !prev_bclk) begin
               if (rise_ok && (cyc - last_rise) < 4*BCLK_DIV)
                  check("bclk_period", 64'(cyc - last_rise), 64'(BCLK_DIV));
               rise_ok   = 1;
               last_rise = cyc;
               if (factive && fcnt < FBITS) begin
                  cap_ws = {cap_ws[FBITS-2:0], ws};
                  cap_sd = {cap_sd[FBITS-2:0], sd};
                  fcnt++;
                  if (fcnt == FBITS) check_frame();
               end else begin
                  fail_evt("extra_bclk");
               end
            end
            prev_bclk = bclk;
            if (s_bus.s_rdy) begin
               if (factive) check("frame_len", 64'(fcnt), 64'(FBITS));
               if (rdy_ok && (cyc - last_rdy) < 2*FRAME)
                  check("rdy_interval", 64'(cyc - last_rdy), 64'(FRAME));
               rdy_ok = 1; last_rdy = cyc; factive = 1; fcnt = 0;
            end
            if (s_bus.s_rdy || underrun)
               check("underrun_pulse", 64'(underrun), 64'(s_bus.s_rdy && !s_bus.s_vld));
            check("underrun_cnt", 64'(underrun_cnt), 64'(mdl_cnt));
         end
      end
   end

   task automatic wait_hs(input int n);
      int target, budget;
      target = hs_cnt + n;
      budget = n*(FRAME + 64) + 600;
      while (hs_cnt < target && budget > 0) begin
         @(posedge clk);
         #3;
         budget--;
      end
      if (hs_cnt < target) fail_evt("hs_timeout");
   endtask

   initial begin : p_watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin : p_seq
      rst_n = 1'b0;
      en    = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_outputs", 64'({bclk, ws, sd, s_bus.s_rdy, underrun}), 64'(0));
      check("rst_cnt", 64'(underrun_cnt), 64'(0));
      @(posedge clk); #3;
      rst_n = 1'b1;

      // Directed pair, counting stream, underrun in the middle, then random pairs.
      stim_q.push_back('{1'b1, {24'hA5A5A5, 24'h5A5A5A}});
      for (int i = 0; i < 4; i++)
         stim_q.push_back('{1'b1, {24'(16*i + 1), 24'(16*i + 2)}});
      stim_q.push_back('{1'b1, rnd_pair()});
      stim_q.push_back('{1'b0, '0});
      stim_q.push_back('{1'b1, rnd_pair()});
      for (int i = 0; i < 6; i++)
         stim_q.push_back('{($urandom_range(0, 3) != 0), rnd_pair()});
      repeat (3) @(posedge clk); #3;
      en = 1'b1;
      wait_hs(14);

      // Drop en at bit 20; the frame must finish and the block go idle.
      wait_hs(1);
      repeat (20*BCLK_DIV) @(posedge clk);
      #3;
      en = 1'b0;
      repeat (FRAME - 20*BCLK_DIV + 8) @(posedge clk);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         check("idle_outputs", 64'({bclk, ws, sd, s_bus.s_rdy, underrun}), 64'(0));
      end
      stim_q.push_back('{1'b1, rnd_pair()});
      repeat (2) @(posedge clk); #3;
      en = 1'b1;
      @(negedge clk);
      check("rdy_on_en", 64'(s_bus.s_rdy), 64'(1));

      // Asynchronous reset at bit 40.
      @(posedge clk); #3;
      repeat (40*BCLK_DIV) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_pins", 64'({bclk, ws, sd, s_bus.s_rdy, underrun}), 64'(0));
      check("async_rst_cnt", 64'(underrun_cnt), 64'(0));
      exp_q.delete();
      stim_q.delete();
      mdl_cnt = '0;
      for (int i = 0; i < 3; i++) stim_q.push_back('{1'b1, rnd_pair()});
      repeat (3) @(posedge clk); #3;
      rst_n = 1'b1;
      wait_hs(3);

      // Counter saturation: preload near the top, then starve the stream.
      wait_hs(1);
      force dut.underrun_cnt_q = 16'hFFFE;
      mdl_cnt = 16'hFFFE;
      @(posedge clk); #3;
      release dut.underrun_cnt_q;
      wait_hs(3);
      check("cnt_saturate", 64'(underrun_cnt), 64'(16'hFFFF));

      en = 1'b0;
      repeat (FRAME + 20) @(posedge clk);
      check("scoreboard_drain", 64'(exp_q.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
